// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake register slices.
//   hs_state_e : slice occupancy state (HS_EMPTY / HS_BUSY / HS_FULL)
//   hs_valid   : downstream valid implied by a state
//   hs_ready   : upstream ready implied by a state
package handshake_pkg;

    typedef enum logic [1:0] {
        HS_EMPTY = 2'd0,
        HS_BUSY  = 2'd1,
        HS_FULL  = 2'd2
    } hs_state_e;

    function automatic logic hs_valid(input hs_state_e st);
        return (st == HS_BUSY) || (st == HS_FULL);
    endfunction

    function automatic logic hs_ready(input hs_state_e st);
        return (st == HS_EMPTY) || (st == HS_BUSY);
    endfunction

endpackage

// File: rtl/handshake_skid_dff.sv
// Valid/ready register slice with registered forward and backward paths (2-entry skid buffer).
// Every output is driven straight from a flop, so no input reaches an output combinationally.
// Full throughput (1 beat/cycle), forward latency 1 cycle.
//
// Optional feature: define HANDSHAKE_SKID_FLUSH_EN to add flush_i, which empties the slice
// on the next edge, discarding any transfer in that cycle.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   data_i   upstream payload
//   valid_i  upstream beat valid
//   ready_o  upstream may transfer (registered)
//   data_o   downstream payload (registered)
//   valid_o  downstream beat valid (registered)
//   ready_i  downstream accepts beat
//   flush_i  synchronous flush (only with HANDSHAKE_SKID_FLUSH_EN)
module handshake_skid_dff
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
`ifdef HANDSHAKE_SKID_FLUSH_EN
    input  logic                  flush_i,
`endif
    input  logic                  ready_i
);

    hs_state_e             state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  acc_in, acc_out;

    assign acc_in  = valid_i & ready_q;
    assign acc_out = valid_q & ready_i;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;

        unique case (state_q)
            HS_EMPTY: begin
                if (acc_in) begin
                    state_d = HS_BUSY;
                    data_d  = data_i;
                end
            end
            HS_BUSY: begin
                if (acc_in && !acc_out) begin
                    state_d = HS_FULL;
                    skid_d  = data_i;
                end else if (!acc_in && acc_out) begin
                    state_d = HS_EMPTY;
                end else if (acc_in && acc_out) begin
                    data_d = data_i;
                end
            end
            HS_FULL: begin
                // ready_o is low here, so acc_in cannot occur.
                if (acc_out) begin
                    state_d = HS_BUSY;
                    data_d  = skid_q;
                end
            end
            default: state_d = HS_EMPTY;
        endcase

`ifdef HANDSHAKE_SKID_FLUSH_EN
        // Stored payload may still be written; it is invisible once valid_o is low.
        if (flush_i) begin
            state_d = HS_EMPTY;
        end
`endif

        // Handshake outputs are registered alongside the state, not decoded from state_q.
        valid_d = hs_valid(state_d);
        ready_d = hs_ready(state_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HS_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Payload registers carry no reset; their content is qualified by valid_q.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        skid_q <= skid_d;
    end

    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_handshake_skid_dff.sv
module tb_handshake_skid_dff;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
`ifdef HANDSHAKE_SKID_FLUSH_EN
    logic          flush_i;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    handshake_skid_dff #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
`ifdef HANDSHAKE_SKID_FLUSH_EN
        .flush_i (flush_i),
`endif
        .ready_i (ready_i)
    );

    typedef struct {
        logic          vin;
        logic [DW-1:0] din;
        logic          rin;
        logic          exp_v;
        logic          exp_r;
        logic          chk_d;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
    endtask

    logic [DW-1:0] sb[$];
    logic [DW-1:0] cur_d, prev_d;
    logic          cur_v, ain, aout, prev_stall;
    logic [DW-1:0] next_val;
    int            n_in, n_out;

    initial begin
        drive(1'b0, '0, 1'b0);
`ifdef HANDSHAKE_SKID_FLUSH_EN
        flush_i = 1'b0;
`endif
        rst = 1'b1;
        #12;
        chk("reset_valid", {63'd0, valid_o}, 64'd0);
        chk("reset_ready", {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Backpressure, blocked upstream while FULL, simultaneous in/out in BUSY.
        //        vin  din      rin  v  r  chk d
        vecs[0]  = '{1'b1, 64'h11, 1'b0, 1'b1, 1'b1, 1'b1, 64'h11};
        vecs[1]  = '{1'b1, 64'h22, 1'b0, 1'b1, 1'b0, 1'b1, 64'h11};
        vecs[2]  = '{1'b1, 64'h99, 1'b0, 1'b1, 1'b0, 1'b1, 64'h11};
        vecs[3]  = '{1'b1, 64'h99, 1'b1, 1'b1, 1'b1, 1'b1, 64'h22};
        vecs[4]  = '{1'b1, 64'h99, 1'b1, 1'b1, 1'b1, 1'b1, 64'h99};
        vecs[5]  = '{1'b0, 64'h00, 1'b1, 1'b0, 1'b1, 1'b0, 64'h00};
        vecs[6]  = '{1'b1, 64'h33, 1'b0, 1'b1, 1'b1, 1'b1, 64'h33};
        vecs[7]  = '{1'b1, 64'h44, 1'b1, 1'b1, 1'b1, 1'b1, 64'h44};
        vecs[8]  = '{1'b0, 64'h00, 1'b0, 1'b1, 1'b1, 1'b1, 64'h44};
        vecs[9]  = '{1'b1, 64'h55, 1'b1, 1'b1, 1'b1, 1'b1, 64'h55};
        vecs[10] = '{1'b0, 64'h00, 1'b1, 1'b0, 1'b1, 1'b0, 64'h00};
        vecs[11] = '{1'b0, 64'h00, 1'b0, 1'b0, 1'b1, 1'b0, 64'h00};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].vin, vecs[i].din, vecs[i].rin);
            step();
            chk($sformatf("vec%0d_valid", i), {63'd0, valid_o}, {63'd0, vecs[i].exp_v});
            chk($sformatf("vec%0d_ready", i), {63'd0, ready_o}, {63'd0, vecs[i].exp_r});
            if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp_d);
        end

        // Reset mid-traffic: fill to FULL, assert reset between edges.
        drive(1'b1, 64'h11, 1'b0);
        step();
        drive(1'b1, 64'h22, 1'b0);
        step();
        chk("pre_rst_ready", {63'd0, ready_o}, 64'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, valid_o}, 64'd0);
        chk("async_rst_ready", {63'd0, ready_o}, 64'd1);
        #1;
        rst = 1'b0;
        drive(1'b1, 64'hA5, 1'b0);
        step();
        chk("post_rst_valid", {63'd0, valid_o}, 64'd1);
        chk("post_rst_data", data_o, 64'hA5);
        chk("post_rst_ready", {63'd0, ready_o}, 64'd1);
        drive(1'b0, '0, 1'b1);
        step();
        chk("post_rst_drain", {63'd0, valid_o}, 64'd0);

        // Streaming at full rate.
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, DW'(i), 1'b1);
            step();
            chk($sformatf("stream%0d_data", i), data_o, DW'(i));
            chk($sformatf("stream%0d_valid", i), {63'd0, valid_o}, 64'd1);
            chk($sformatf("stream%0d_ready", i), {63'd0, ready_o}, 64'd1);
        end
        drive(1'b0, '0, 1'b1);
        step();
        chk("stream_end_valid", {63'd0, valid_o}, 64'd0);

        // Random traffic against an in-order queue model.
        n_in       = 0;
        n_out      = 0;
        next_val   = 64'h1000;
        cur_v      = 1'b0;
        cur_d      = '0;
        prev_stall = 1'b0;
        prev_d     = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!cur_v) begin
                cur_v = ($urandom_range(0, 1) == 1);
                cur_d = next_val;
            end
            drive(cur_v, cur_d, ($urandom_range(0, 9) < 3));
            ain  = valid_i & ready_o;
            aout = valid_o & ready_i;
            prev_stall = valid_o & ~ready_i;
            prev_d     = data_o;
            step();
            if (aout) begin
                if (sb.size() == 0) begin
                    chk("rand_spurious_out", 64'd1, 64'd0);
                end else begin
                    chk("rand_order", prev_d, sb.pop_front());
                end
                n_out++;
            end
            if (ain) begin
                sb.push_back(cur_d);
                n_in++;
                next_val = next_val + 1;
                cur_v    = 1'b0;
            end
            chk("rand_valid", {63'd0, valid_o}, {63'd0, sb.size() > 0});
            chk("rand_ready", {63'd0, ready_o}, {63'd0, sb.size() < 2});
            if (sb.size() > 0) chk("rand_head", data_o, sb[0]);
            if (prev_stall) chk("rand_stall_stable", data_o, prev_d);
        end
        drive(1'b0, '0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            aout   = valid_o & ready_i;
            prev_d = data_o;
            step();
            if (aout) begin
                if (sb.size() == 0) chk("drain_spurious_out", 64'd1, 64'd0);
                else chk("drain_order", prev_d, sb.pop_front());
                n_out++;
            end
        end
        chk("rand_count", DW'(n_out), DW'(n_in));
        chk("rand_empty", {63'd0, valid_o}, 64'd0);

`ifdef HANDSHAKE_SKID_FLUSH_EN
        drive(1'b1, 64'h55, 1'b0);
        step();
        drive(1'b1, 64'h66, 1'b0);
        step();
        chk("flush_full_ready", {63'd0, ready_o}, 64'd0);
        drive(1'b0, '0, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_valid", {63'd0, valid_o}, 64'd0);
        chk("flush_ready", {63'd0, ready_o}, 64'd1);
        drive(1'b1, 64'h77, 1'b1);
        step();
        chk("flush_next_valid", {63'd0, valid_o}, 64'd1);
        chk("flush_next_data", data_o, 64'h77);
        drive(1'b0, '0, 1'b1);
        step();
        chk("flush_after_valid", {63'd0, valid_o}, 64'd0);
        step();
        chk("flush_stays_empty", {63'd0, valid_o}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
